// File: rtl/pipearch_region_responder_if.sv
// ============================================================================
// Module      : pipearch_region_responder_if
// Description : Request/response bundle between a region read/write engine
//               (master) and the region responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipearch_region_responder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 10
);
  logic                  fifo_mode;
  logic                  clear;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  busy;

  modport master (
    output fifo_mode, clear, we, waddr, wdata, re, raddr,
    input  rvalid, rdata, full, empty, count, overflow, underflow, busy
  );

  modport slave (
    input  fifo_mode, clear, we, waddr, wdata, re, raddr,
    output rvalid, rdata, full, empty, count, overflow, underflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/pipearch_region_responder.sv
// ============================================================================
// Module      : pipearch_region_responder
// Description : Storage-side responder for one on-chip data region. Services
//               addressed or FIFO-ordered writes/reads into a dual-port line
//               store and returns read data two cycles after the request.
//               Optional build macro PIPEARCH_REGION_RDATA_BYPASS_EN enables
//               write-first forwarding and empty-FIFO pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipearch_region_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 10
) (
  input wire clk,
  input wire reset_n,
  pipearch_region_responder_if.slave bus
);

  localparam int                  c_lines = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  r_mode;
  logic                  r_v1;
  logic                  r_v2;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_ovf;
  logic                  r_unf;
  logic [DATA_WIDTH-1:0] r_mem [c_lines];
  logic [DATA_WIDTH-1:0] r_bram_q;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_busy;
  logic                  w_mode_nxt;
  logic                  w_cnt_zero;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_fwd;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  assign w_busy     = r_v1 | r_v2;
  // The mode may only change when nothing is in flight and nothing is requested.
  assign w_mode_nxt = (!w_busy && !bus.we && !bus.re) ? bus.fifo_mode : r_mode;
  assign w_cnt_zero = (r_count == '0);

  // Request acceptance, line addressing and same-line forwarding decision.
  always_comb begin
    w_rd_acc  = 1'b0;
    w_wr_acc  = 1'b0;
    w_fwd     = 1'b0;
    w_wr_addr = r_mode ? r_wr_ptr : bus.waddr;
    w_rd_addr = r_mode ? r_rd_ptr : bus.raddr;
    if (!bus.clear) begin
      if (!r_mode) begin
        w_rd_acc = bus.re;
        w_wr_acc = bus.we;
      end else begin
        w_rd_acc = bus.re && !w_cnt_zero;
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
        if (bus.re && bus.we && w_cnt_zero) w_rd_acc = 1'b1;
`endif
        // A full FIFO still takes a write when a read frees a slot this cycle.
        w_wr_acc = bus.we && (!r_full || w_rd_acc);
      end
    end
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
    // In FIFO mode only the empty case forwards; a full FIFO also has
    // rd_ptr == wr_ptr but must return the oldest stored line.
    w_fwd = w_rd_acc && w_wr_acc && (r_mode ? w_cnt_zero : (bus.waddr == bus.raddr));
`endif
  end

  // Occupancy moves only when exactly one side of the FIFO is accepted.
  always_comb begin
    w_count_nxt = r_count;
    if (r_mode) begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   w_count_nxt = r_count - (ADDR_WIDTH + 1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Latched operating mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mode <= 1'b0;
    else          r_mode <= w_mode_nxt;
  end

  // FIFO pointers, occupancy and registered full/empty; addressed mode keeps them cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (bus.clear || !w_mode_nxt) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Sticky overflow/underflow, raised only for rejected FIFO-mode requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (r_mode) begin
      if (bus.we && !w_wr_acc) r_ovf <= 1'b1;
      if (bus.re && !w_rd_acc) r_unf <= 1'b1;
    end
  end

  // Line store with its read register; read-first unless forwarding applies.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= bus.wdata;
    if (w_rd_acc) r_bram_q <= w_fwd ? bus.wdata : r_mem[w_rd_addr];
  end

  // Two-stage read valid pipeline and output data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      r_v2 <= r_v1;
      if (r_v1) r_rdata <= r_bram_q;
    end
  end

  assign bus.rvalid    = r_v2;
  assign bus.rdata     = r_rdata;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
  assign bus.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_pipearch_region_responder.sv
// ============================================================================
// Module      : tb_pipearch_region_responder
// Description : Self-checking bench for pipearch_region_responder with a
//               queue-based reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipearch_region_responder;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  pipearch_region_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pipearch_region_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] fifo_q [$];
  rd_t           pend [$];
  int            edge_n = 0;
  logic          mode_m = 1'b0;
  logic          ovf_m  = 1'b0;
  logic          unf_m  = 1'b0;
  logic          busy_pre, rd_ok, wr_ok, pass, exp_rv;
  logic [DW-1:0] d;
  int            cnt, ecnt;

  always @(posedge clk) begin
    edge_n++;
    if (!reset_n) begin
      fifo_q.delete();
      pend.delete();
      mode_m = 1'b0;
      ovf_m  = 1'b0;
      unf_m  = 1'b0;
    end else begin
      busy_pre = (pend.size() != 0);
      if (bus.clear) begin
        fifo_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end else if (!mode_m) begin
        if (bus.re) begin
          d = mem_m[bus.raddr];
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
          if (bus.we && bus.waddr == bus.raddr) d = bus.wdata;
`endif
          pend.push_back('{edge_n + 1, d});
        end
        if (bus.we) mem_m[bus.waddr] = bus.wdata;
      end else begin
        cnt   = fifo_q.size();
        rd_ok = bus.re && (cnt > 0);
        pass  = 1'b0;
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
        if (bus.re && bus.we && cnt == 0) begin
          rd_ok = 1'b1;
          pass  = 1'b1;
        end
`endif
        wr_ok = bus.we && (cnt < DEPTH || rd_ok);
        if (rd_ok) begin
          d = pass ? bus.wdata : fifo_q.pop_front();
          pend.push_back('{edge_n + 1, d});
        end
        if (wr_ok && !pass) fifo_q.push_back(bus.wdata);
        if (bus.re && !rd_ok) unf_m = 1'b1;
        if (bus.we && !wr_ok) ovf_m = 1'b1;
      end
      if (!busy_pre && !bus.we && !bus.re) begin
        mode_m = bus.fifo_mode;
        if (!mode_m) fifo_q.delete();
      end
    end
    while (pend.size() > 0 && pend[0].due < edge_n) void'(pend.pop_front());

    #1;
    exp_rv = (pend.size() > 0) && (pend[0].due == edge_n);
    chk("m_rvalid", bus.rvalid, exp_rv);
    if (exp_rv) chk("m_rdata", bus.rdata, pend[0].data);
    chk("m_busy", bus.busy, pend.size() != 0);
    ecnt = mode_m ? fifo_q.size() : 0;
    chk("m_count", bus.count, ecnt);
    chk("m_full", bus.full, ecnt == DEPTH);
    chk("m_empty", bus.empty, ecnt == 0);
    chk("m_overflow", bus.overflow, ovf_m);
    chk("m_underflow", bus.underflow, unf_m);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    @(negedge clk);
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra);
    @(negedge clk);
    bus.we    = w;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.re    = r;
    bus.raddr = ra;
    bus.clear = 1'b0;
  endtask

  // Call right after driving a read: checks the exact 2-cycle latency.
  task automatic read_lit(input string nm, input logic [DW-1:0] exp);
    @(posedge clk); #2;
    chk({nm, "_early"}, bus.rvalid, 0);
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b0;
    @(posedge clk); #2;
    chk({nm, "_rvalid"}, bus.rvalid, 1);
    chk({nm, "_rdata"}, bus.rdata, exp);
  endtask

  // Back-to-back FIFO reads expecting consecutive values starting at first.
  task automatic read_burst(input string nm, input int n, input int first);
    int got = 0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      bus.we    = 1'b0;
      bus.clear = 1'b0;
      bus.re    = (i < n);
      @(posedge clk); #2;
      if (bus.rvalid) begin
        chk(nm, bus.rdata, first + got);
        got++;
      end
    end
    chk({nm, "_nreads"}, got, n);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fifo_mode = 1'b0;
    bus.clear     = 1'b0;
    bus.we        = 1'b0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.re        = 1'b0;
    bus.raddr     = '0;

    // Reset values
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_empty", bus.empty, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", bus.rvalid, 0);

    // Addressed write then read
    drive(1'b1, 2'd3, 32'hA5, 1'b0, 2'd0);
    idle();
    idle();
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
    read_lit("addr_rd", 32'hA5);

    // Addressed same-cycle read/write
    drive(1'b1, 2'd2, 32'h11, 1'b0, 2'd0);
    idle();
    drive(1'b1, 2'd2, 32'h22, 1'b1, 2'd2);
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
    read_lit("same_cyc", 32'h22);
`else
    read_lit("same_cyc", 32'h11);
`endif
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
    read_lit("after_wr", 32'h22);

    // Switch to FIFO mode while idle
    @(negedge clk);
    bus.fifo_mode = 1'b1;
    idle();
    idle();

    // Fill to full, then overflow
    for (int i = 1; i <= 4; i++) drive(1'b1, 2'd0, DW'(i), 1'b0, 2'd0);
    idle();
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 4);
    drive(1'b1, 2'd0, 32'd5, 1'b0, 2'd0);
    idle();
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_count", bus.count, 4);
    read_burst("fifo_order", 4, 1);
    chk("drain_empty", bus.empty, 1);
    pulse_clear();
    chk("clr_ovf", bus.overflow, 0);

    // Pointer wrap: two rounds of 3 writes / 3 reads
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) drive(1'b1, 2'd0, DW'(10 + 16 * r + j), 1'b0, 2'd0);
      read_burst("wrap_order", 3, 10 + 16 * r);
    end
    chk("wrap_count", bus.count, 0);
    chk("wrap_ovf", bus.overflow, 0);
    chk("wrap_unf", bus.underflow, 0);

    // Underflow on empty, then clear
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
    @(posedge clk); #2;
    chk("unf_no_rv0", bus.rvalid, 0);
    idle();
    @(posedge clk); #2;
    chk("unf_no_rv1", bus.rvalid, 0);
    chk("unf_flag", bus.underflow, 1);
    pulse_clear();
    chk("clr_unf", bus.underflow, 0);
    chk("clr_empty", bus.empty, 1);

    // Simultaneous write/read on empty FIFO
    drive(1'b1, 2'd0, 32'h77, 1'b1, 2'd0);
    idle();
`ifdef PIPEARCH_REGION_RDATA_BYPASS_EN
    chk("pass_count", bus.count, 0);
    chk("pass_unf", bus.underflow, 0);
`else
    chk("pass_count", bus.count, 1);
    chk("pass_unf", bus.underflow, 1);
`endif
    idle();
    idle();

    // Reset with a read in flight
    drive(1'b1, 2'd0, 32'h55, 1'b0, 2'd0);
    drive(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
    @(negedge clk);
    bus.re  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_rvalid", bus.rvalid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_rdata", bus.rdata, 0);
    chk("arst_unf", bus.underflow, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
